chacha_block_reader: RTL

Reads one 16-word ChaCha state/keystream block out of the core's word port, one word at a time. Serializes each word into bytes on a valid/ready byte stream toward the pin-level output. It is the read-side counterpart of the word writer that loads the core through the same addr/data port. One block is 64 bytes.

---
 rtl/chacha_block_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/chacha_block_reader.sv
// Reads one block of WORDS 32-bit words from the core's word port and
// serializes each word into bytes on a valid/ready byte stream.
module chacha_block_reader #(
  parameter int unsigned WORDS         = 16,
  parameter int unsigned READ_LATENCY  = 1,
  parameter bit          BYTE_ORDER_LE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [3:0]  core_addr,
  input  logic [31:0] core_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS - 1);
  localparam logic [1:0]       WAIT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] word_q, word_d;
  logic [1:0]       wait_q, wait_d;
  logic [1:0]       byte_q, byte_d;
  logic [31:0]      shift_q, shift_d;
  logic [3:0]       addr_q, addr_d;
  logic             handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      wait_q  <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    wait_d    = wait_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    handshake = (state_q == EMIT) && out_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          word_d  = '0;
          wait_d  = '0;
          addr_d  = '0;
        end
      end
      FETCH: begin
        if (wait_q == WAIT_LAST) begin
          shift_d = core_data;
          byte_d  = '0;
          state_d = EMIT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      EMIT: begin
        if (handshake) begin
          // The outgoing byte always sits at the same end of the shift register.
          shift_d = BYTE_ORDER_LE ? {8'h00, shift_q[31:8]} : {shift_q[23:0], 8'h00};
          byte_d  = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (word_q == WORD_LAST) begin
              state_d = FINISH;
            end else begin
              word_d  = word_q + 1'b1;
              addr_d  = 4'(word_q + 1'b1);
              wait_d  = '0;
              state_d = FETCH;
            end
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides anything the active state decided, including a handshake.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      word_d  = '0;
      wait_d  = '0;
      byte_d  = '0;
      addr_d  = '0;
    end
  end

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == FETCH) || (state_q == EMIT);
  assign done      = (state_q == FINISH);
  assign core_addr = addr_q;
  assign out_data  = out_valid ? (BYTE_ORDER_LE ? shift_q[7:0] : shift_q[31:24]) : '0;

endmodule
